// File: rtl/dram_cpu_share_pkg.sv
// Shared definitions for the DRAM CPU-port sharer: ownership state encoding,
// default address width and the Z80 run-length counter helper.
package dram_cpu_share_pkg;

  localparam int AW_DEFAULT = 21;
  localparam int ZRUN_W     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ZOWN = 2'd1,
    DOWN = 2'd2
  } own_state_e;

  // Saturating increment: the run length never climbs past the forcing limit.
  function automatic logic [ZRUN_W-1:0] zrun_step(input logic [ZRUN_W-1:0] cur,
                                                  input logic [ZRUN_W-1:0] lim);
    return (cur >= lim) ? lim : cur + 1'b1;
  endfunction

endpackage

// File: rtl/dram_cpu_share.sv
// Shares the arbiter's single CPU request port between the Z80 memory path and a
// DMA engine. Z80 has priority; a run-length counter bounds how long DMA can starve.
module dram_cpu_share
  import dram_cpu_share_pkg::*;
#(
  parameter int AW       = AW_DEFAULT,
  parameter int MAX_ZRUN = 4
) (
  input  logic          fclk,
  input  logic          rst_n,
  input  logic          z_req,
  input  logic          z_rnw,
  input  logic [AW-1:0] z_addr,
  input  logic          z_wrbsel,
  input  logic [7:0]    z_wrdata,
  output logic          z_strobe,
  output logic [15:0]   z_rddata,
  input  logic          d_req,
  input  logic          d_rnw,
  input  logic [AW-1:0] d_addr,
  input  logic          d_wrbsel,
  input  logic [7:0]    d_wrdata,
  output logic          d_strobe,
  output logic [15:0]   d_rddata,
  output logic          cpu_req,
  output logic          cpu_rnw,
  output logic [AW-1:0] cpu_addr,
  output logic          cpu_wrbsel,
  output logic [7:0]    cpu_wrdata,
  input  logic [15:0]   cpu_rddata,
  input  logic          cpu_strobe,
  output logic          dma_active,
  output logic [1:0]    dbg_state
);

  // Handshake: a requester raises *_req with stable fields and holds both until
  // its *_strobe pulse; the transfer is complete in that strobe cycle. Toward the
  // arbiter, cpu_req stays high with stable cpu_* fields until cpu_strobe, and
  // is withdrawn combinationally in the strobe cycle itself.

  localparam logic [ZRUN_W-1:0] ZRUN_LIM = ZRUN_W'(MAX_ZRUN);

  own_state_e        state_q, state_d;
  logic [ZRUN_W-1:0] zrun_q, zrun_d;
  logic              dma_active_q;
  logic              z_blocked;

  assign z_blocked = d_req & (zrun_q >= ZRUN_LIM);

  always_comb begin
    state_d = state_q;
    zrun_d  = zrun_q;
    case (state_q)
      IDLE: begin
        if (z_req && !z_blocked) begin
          state_d = ZOWN;
          zrun_d  = d_req ? zrun_step(zrun_q, ZRUN_LIM) : '0;
        end else if (d_req) begin
          state_d = DOWN;
          zrun_d  = '0;
        end
      end
      // Always pass through IDLE after a completion so the loser gets a look-in.
      ZOWN, DOWN: begin
        if (cpu_strobe) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      zrun_q       <= '0;
      dma_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      zrun_q       <= zrun_d;
      dma_active_q <= (state_d == DOWN);
    end
  end

  assign cpu_req    = (state_q != IDLE) & ~cpu_strobe;
  assign cpu_rnw    = dma_active_q ? d_rnw    : z_rnw;
  assign cpu_addr   = dma_active_q ? d_addr   : z_addr;
  assign cpu_wrbsel = dma_active_q ? d_wrbsel : z_wrbsel;
  assign cpu_wrdata = dma_active_q ? d_wrdata : z_wrdata;

  // A strobe arriving in IDLE belongs to an abandoned cycle and is dropped.
  assign z_strobe   = cpu_strobe & (state_q == ZOWN);
  assign d_strobe   = cpu_strobe & (state_q == DOWN);
  assign z_rddata   = cpu_rddata;
  assign d_rddata   = cpu_rddata;

  assign dma_active = dma_active_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_dram_cpu_share.sv
// Randomized bench for dram_cpu_share: an arbiter responder and two requesters
// drive traffic; a grant-level reference model feeds queues that a monitor checks.
module tb_dram_cpu_share;

  localparam int AW       = 21;
  localparam int MAX_ZRUN = 4;
  localparam int GW       = 32;
  localparam int SW       = 17;

  logic          fclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          z_req = 1'b0, z_rnw = 1'b0, z_wrbsel = 1'b0;
  logic [AW-1:0] z_addr = '0;
  logic [7:0]    z_wrdata = '0;
  logic          d_req = 1'b0, d_rnw = 1'b0, d_wrbsel = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [7:0]    d_wrdata = '0;
  logic [15:0]   cpu_rddata = '0;
  logic          cpu_strobe = 1'b0;

  logic          z_strobe, d_strobe, cpu_req, cpu_rnw, cpu_wrbsel, dma_active;
  logic [15:0]   z_rddata, d_rddata;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wrdata;
  logic [1:0]    dbg_state;

  dram_cpu_share #(.AW(AW), .MAX_ZRUN(MAX_ZRUN)) dut (
    .fclk(fclk), .rst_n(rst_n),
    .z_req(z_req), .z_rnw(z_rnw), .z_addr(z_addr), .z_wrbsel(z_wrbsel),
    .z_wrdata(z_wrdata), .z_strobe(z_strobe), .z_rddata(z_rddata),
    .d_req(d_req), .d_rnw(d_rnw), .d_addr(d_addr), .d_wrbsel(d_wrbsel),
    .d_wrdata(d_wrdata), .d_strobe(d_strobe), .d_rddata(d_rddata),
    .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr),
    .cpu_wrbsel(cpu_wrbsel), .cpu_wrdata(cpu_wrdata),
    .cpu_rddata(cpu_rddata), .cpu_strobe(cpu_strobe),
    .dma_active(dma_active), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 fclk = ~fclk;

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [GW-1:0] exp_q[$];     // expected grants: {dma, rnw, addr, wrbsel, wrdata}
  logic [SW-1:0] exp_stb_q[$]; // expected completions: {dma, rddata}

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Owner: 0 none, 1 Z80, 2 DMA. z_streak counts Z80 grants taken while DMA waited.
  int m_own = 0;
  int m_cur = 0;
  int z_streak = 0;

  always @(negedge fclk) begin
    if (!rst_n) begin
      m_own = 0; m_cur = 0; z_streak = 0;
    end else begin
      m_cur = m_own;
      if (m_own == 0) begin
        if (z_req && !(d_req && z_streak >= MAX_ZRUN)) begin
          exp_q.push_back({1'b0, z_rnw, z_addr, z_wrbsel, z_wrdata});
          z_streak = d_req ? ((z_streak + 1 > MAX_ZRUN) ? MAX_ZRUN : z_streak + 1) : 0;
          m_own = 1;
        end else if (d_req) begin
          exp_q.push_back({1'b1, d_rnw, d_addr, d_wrbsel, d_wrdata});
          z_streak = 0;
          m_own = 2;
        end
      end else if (cpu_strobe) begin
        exp_stb_q.push_back({(m_own == 2), cpu_rddata});
        m_own = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  int   z_done_cnt = 0;
  int   d_done_cnt = 0;
  logic prev_req = 1'b0;

  always @(negedge fclk) begin
    logic [GW-1:0] eg;
    logic [SW-1:0] es;
    #1;
    if (!rst_n) begin
      prev_req = 1'b0;
    end else begin
      check("cpu_req", {31'd0, cpu_req}, {31'd0, (m_cur != 0) && !cpu_strobe});
      check("dma_active", {31'd0, dma_active}, {31'd0, m_cur == 2});
      if (cpu_strobe) check("req_in_strobe", {31'd0, cpu_req}, 32'd0);
      if (cpu_req && !prev_req) begin
        if (exp_q.size() == 0) check("grant_unexpected", 32'd1, 32'd0);
        else begin
          eg = exp_q.pop_front();
          check("grant", {dma_active, cpu_rnw, cpu_addr, cpu_wrbsel, cpu_wrdata}, eg);
        end
      end
      if (z_strobe || d_strobe) begin
        if (z_strobe) z_done_cnt++;
        if (d_strobe) d_done_cnt++;
        if (exp_stb_q.size() == 0) check("strobe_unexpected", 32'd1, 32'd0);
        else begin
          es = exp_stb_q.pop_front();
          check("z_strobe", {31'd0, z_strobe}, {31'd0, !es[16]});
          check("d_strobe", {31'd0, d_strobe}, {31'd0, es[16]});
          check("rddata", {16'd0, es[16] ? d_rddata : z_rddata}, {16'd0, es[15:0]});
        end
      end
      prev_req = cpu_req;
    end
  end

  // ---------------- driver ----------------
  int z_pct = 0, d_pct = 0, keep_pct = 0, spur_pct = 0;
  int lat_fix = -1, lat_max = 4;
  bit use_fix = 1'b0;
  logic          fx_rnw = 1'b1, fx_wrbsel = 1'b0;
  logic [AW-1:0] fx_addr = '0;
  logic [7:0]    fx_wrdata = '0;
  bit arb_busy = 1'b0;
  int arb_cnt = 0;
  int z_used = 0, d_used = 0;

  task automatic new_z();
    z_req    = 1'b1;
    z_used   = z_done_cnt;
    z_rnw    = use_fix ? fx_rnw    : 1'($urandom_range(0, 1));
    z_addr   = use_fix ? fx_addr   : AW'($urandom);
    z_wrbsel = use_fix ? fx_wrbsel : 1'($urandom_range(0, 1));
    z_wrdata = use_fix ? fx_wrdata : 8'($urandom);
  endtask

  task automatic new_d();
    d_req    = 1'b1;
    d_used   = d_done_cnt;
    d_rnw    = use_fix ? fx_rnw    : 1'($urandom_range(0, 1));
    d_addr   = use_fix ? fx_addr   : AW'($urandom);
    d_wrbsel = use_fix ? fx_wrbsel : 1'($urandom_range(0, 1));
    d_wrdata = use_fix ? fx_wrdata : 8'($urandom);
  endtask

  task automatic step();
    logic req_now;
    @(posedge fclk);
    #1;
    cpu_strobe = 1'b0;
    #1;
    req_now = cpu_req;
    if (arb_busy) begin
      if (arb_cnt == 0) begin
        cpu_strobe = 1'b1;
        cpu_rddata = 16'($urandom);
        arb_busy   = 1'b0;
      end else arb_cnt--;
    end else if (req_now) begin
      arb_busy = 1'b1;
      arb_cnt  = (lat_fix >= 0) ? lat_fix : $urandom_range(0, lat_max);
    end else if (spur_pct > 0 && $urandom_range(1, 100) <= spur_pct) begin
      cpu_strobe = 1'b1;
      cpu_rddata = 16'($urandom);
    end
    if (z_req) begin
      if (z_done_cnt != z_used) begin
        if ($urandom_range(1, 100) <= keep_pct) new_z();
        else z_req = 1'b0;
      end
    end else if ($urandom_range(1, 100) <= z_pct) new_z();
    if (d_req) begin
      if (d_done_cnt != d_used) begin
        if ($urandom_range(1, 100) <= keep_pct) new_d();
        else d_req = 1'b0;
      end
    end else if ($urandom_range(1, 100) <= d_pct) new_d();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain();
    int budget;
    z_pct = 0; d_pct = 0; keep_pct = 0; spur_pct = 0;
    budget = 400;
    while ((z_req || d_req || arb_busy || cpu_req) && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) check("drain_timeout", 32'd1, 32'd0);
    run(2);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int budget;
    #3;
    check("rst_cpu_req", {31'd0, cpu_req}, 32'd0);
    check("rst_dma_active", {31'd0, dma_active}, 32'd0);
    check("rst_strobes", {30'd0, z_strobe, d_strobe}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    @(posedge fclk); #2; rst_n = 1'b1;
    run(2);

    // Z80-only read, fixed latency
    use_fix = 1'b1; fx_rnw = 1'b1; fx_addr = 21'h0ABCD; fx_wrbsel = 1'b0; fx_wrdata = 8'h00;
    lat_fix = 4; z_pct = 100;
    step();
    z_pct = 0;
    run(14);

    // DMA-only write
    fx_rnw = 1'b0; fx_addr = 21'h1F000; fx_wrbsel = 1'b1; fx_wrdata = 8'h5A;
    d_pct = 100;
    step();
    d_pct = 0;
    run(14);
    use_fix = 1'b0;

    // both requesters held continuously: Z80 run limit forces DMA in
    lat_fix = -1; lat_max = 3; z_pct = 100; d_pct = 100; keep_pct = 100;
    run(120);
    drain();

    // random traffic with spurious strobes
    lat_max = 6; z_pct = 30; d_pct = 20; keep_pct = 30; spur_pct = 5;
    run(10000);
    drain();

    // reset in the middle of a DMA ownership
    lat_fix = 10; d_pct = 100;
    budget = 30;
    while (!dma_active && budget > 0) begin
      step();
      budget--;
    end
    d_pct = 0;
    if (budget == 0) check("dma_grant_timeout", 32'd1, 32'd0);
    run(2);
    @(negedge fclk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_cpu_req", {31'd0, cpu_req}, 32'd0);
    check("arst_dma_active", {31'd0, dma_active}, 32'd0);
    check("arst_strobes", {30'd0, z_strobe, d_strobe}, 32'd0);
    check("arst_state", {30'd0, dbg_state}, 32'd0);
    d_req = 1'b0; z_req = 1'b0; arb_busy = 1'b0;
    run(2);
    @(posedge fclk); #2; rst_n = 1'b1;
    lat_fix = 2; spur_pct = 100;
    step();
    spur_pct = 0;
    run(2);
    z_pct = 100;
    step();
    z_pct = 0;
    run(10);
    drain();

    check("grants_left", exp_q.size(), 32'd0);
    check("strobes_left", exp_stb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
